// File: rtl/xor_cipher_pkg.sv
// ---------------------------------------------------------------------------
// xor_cipher_pkg
// Shared encodings for the XOR stream cipher slice:
//   MODE_ECB / MODE_CBC : values of the mode input
//   DIR_ENC  / DIR_DEC  : values of the dir input
//   state_t             : row-tracking state (IDLE = no row open, ACTIVE = row open)
// ---------------------------------------------------------------------------
package xor_cipher_pkg;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    localparam logic DIR_ENC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/xor_cipher_core.sv
// ---------------------------------------------------------------------------
// xor_cipher_core
// Purely combinational per-block cipher function. Holds no state; the
// chaining value is passed in and the updated one handed back.
// Ports:
//   in_data    : plaintext (encrypt) or ciphertext (decrypt) block
//   work_key   : key for this beat (possibly rotated by the caller)
//   cprev      : chaining value for this beat (row iv on the first beat)
//   mode       : MODE_ECB / MODE_CBC
//   dir        : DIR_ENC / DIR_DEC
//   out_data   : result block
//   next_cprev : chaining value for the following beat
// ---------------------------------------------------------------------------
module xor_cipher_core
    import xor_cipher_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] work_key,
    input  logic [W-1:0] cprev,
    input  logic         mode,
    input  logic         dir,
    output logic [W-1:0] out_data,
    output logic [W-1:0] next_cprev
);

    // The XOR is its own inverse, so encrypt and decrypt compute the same
    // output; they only differ in which side of the XOR becomes the next
    // chaining value (always the ciphertext block).
    always_comb begin
        out_data   = in_data ^ work_key;
        next_cprev = cprev;
        case (mode)
            MODE_ECB: begin
                out_data   = in_data ^ work_key;
                next_cprev = cprev;
            end
            MODE_CBC: begin
                out_data   = in_data ^ work_key ^ cprev;
                next_cprev = (dir == DIR_ENC) ? (in_data ^ work_key ^ cprev) : in_data;
            end
            default: begin
                out_data   = in_data ^ work_key;
                next_cprev = cprev;
            end
        endcase
    end

endmodule

// File: rtl/xor_stream_cipher.sv
// ---------------------------------------------------------------------------
// xor_stream_cipher
// XOR block cipher over an image row stream. Every NBLK = HSIZE/BLOCK_SIZE
// accepted beats form one row; key/iv/mode/dir are captured on a row's first
// beat and held for the rest of it. One registered output stage gives a
// latency of one cycle at full throughput.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   key, iv, mode, dir  : row configuration, sampled on the first beat
//   in_valid/in_ready/in_data    : input block stream
//   out_valid/out_ready/out_data : output block stream
//   out_last            : marks the final block of a row
//   busy                : a row is partially accepted
// Build option:
//   XOR_CIPHER_KEY_ROTATE_EN : rotate the key left by the beat index each beat
// ---------------------------------------------------------------------------
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int BLOCK_SIZE = 32,
    parameter int HSIZE      = 768
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BLOCK_SIZE-1:0] key,
    input  logic [BLOCK_SIZE-1:0] iv,
    input  logic                  mode,
    input  logic                  dir,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_SIZE-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_SIZE-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int NBLK  = HSIZE / BLOCK_SIZE;
    localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBLK - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [BLOCK_SIZE-1:0] key_q, key_d;
    logic                  mode_q, mode_d;
    logic                  dir_q, dir_d;
    logic [BLOCK_SIZE-1:0] cprev_q, cprev_d;
    logic                  out_valid_q, out_valid_d;
    logic [BLOCK_SIZE-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    logic                  accept;
    logic                  row_start;
    logic [BLOCK_SIZE-1:0] cur_key;
    logic [BLOCK_SIZE-1:0] cur_cprev;
    logic                  cur_mode;
    logic                  cur_dir;
    logic [BLOCK_SIZE-1:0] work_key;
    logic [BLOCK_SIZE-1:0] core_out;
    logic [BLOCK_SIZE-1:0] core_next;

    // The input is free whenever the output register is empty or draining,
    // which allows a drain and a new acceptance in the same cycle.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign row_start = (state_q == IDLE);

    // On a row's first beat the configuration comes straight from the ports
    // (the registers are only being loaded this cycle); afterwards the
    // latched copy is used so port changes inside a row are ignored.
    always_comb begin
        cur_key   = row_start ? key  : key_q;
        cur_mode  = row_start ? mode : mode_q;
        cur_dir   = row_start ? dir  : dir_q;
        cur_cprev = row_start ? iv   : cprev_q;
    end

`ifdef XOR_CIPHER_KEY_ROTATE_EN
    int unsigned               rot_amt;
    logic [2*BLOCK_SIZE-1:0]   key_dbl;

    // Rotate-left implemented as a shift of the key concatenated with itself;
    // the beat counter is 0 on the row's first beat.
    always_comb begin
        rot_amt  = 32'(beat_q) % BLOCK_SIZE;
        key_dbl  = {cur_key, cur_key} << rot_amt;
        work_key = key_dbl[2*BLOCK_SIZE-1 -: BLOCK_SIZE];
    end
`else
    assign work_key = cur_key;
`endif

    xor_cipher_core #(
        .W(BLOCK_SIZE)
    ) u_core (
        .in_data   (in_data),
        .work_key  (work_key),
        .cprev     (cur_cprev),
        .mode      (cur_mode),
        .dir       (cur_dir),
        .out_data  (core_out),
        .next_cprev(core_next)
    );

    // Row tracking and the output register. With NBLK == 1 the beat counter
    // is always on its last value, so the state never leaves IDLE and every
    // output carries out_last.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        key_d       = key_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        cprev_d     = cprev_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (accept) begin
            if (row_start) begin
                key_d  = key;
                mode_d = mode;
                dir_d  = dir;
            end
            cprev_d     = core_next;
            out_valid_d = 1'b1;
            out_data_d  = core_out;
            out_last_d  = (beat_q == LAST_BEAT);
            if (beat_q == LAST_BEAT) begin
                beat_d  = '0;
                state_d = IDLE;
            end else begin
                beat_d  = beat_q + 1'b1;
                state_d = ACTIVE;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            cprev_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            cprev_q     <= cprev_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_xor_stream_cipher.sv
// ---------------------------------------------------------------------------
// tb_xor_stream_cipher
// Self-checking bench for xor_stream_cipher with BLOCK_SIZE=32, HSIZE=96
// (three blocks per row). A row-level reference model predicts every output
// block; directed rows pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_xor_stream_cipher;

    localparam int BS   = 32;
    localparam int HS   = 96;
    localparam int NBLK = HS / BS;

    localparam logic [31:0] KEY_C = 32'hA5A5A5A5;
    localparam logic [31:0] IV_C  = 32'h0F0F0F0F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BS-1:0] key = '0;
    logic [BS-1:0] iv = '0;
    logic          mode = 1'b0;
    logic          dir = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BS-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BS-1:0] out_data;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    xor_stream_cipher #(
        .BLOCK_SIZE(BS),
        .HSIZE     (HS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .iv       (iv),
        .mode     (mode),
        .dir      (dir),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model: cipher a row prefix from scratch, returning the output
    // of its final element. Written directly from the ECB/CBC rules.
    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        if (s == 0) return v;
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] modelBeat(input logic [31:0] k, input logic [31:0] v,
                                              input logic m, input logic d,
                                              input logic [31:0] ins[$]);
        logic [31:0] c;
        logic [31:0] o;
        logic [31:0] ki;
        c = v;
        o = '0;
        for (int i = 0; i < ins.size(); i++) begin
            ki = k;
`ifdef XOR_CIPHER_KEY_ROTATE_EN
            ki = rotl(k, i % 32);
`endif
            if (m == 1'b0) begin
                o = ins[i] ^ ki;
            end else begin
                o = ins[i] ^ ki ^ c;
                c = d ? ins[i] : o;
            end
        end
        return o;
    endfunction

    // Model state maintained by the compare process
    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic [31:0] row_in[$];
    logic [31:0] out_log[$];
    logic        last_log[$];
    logic [31:0] m_key, m_iv;
    logic        m_mode, m_dir;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        pend_out = 1'b0;

    // Compare process: sampled on the falling edge, half a cycle away from the
    // edge where state changes and where the driver updates inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_data.delete();
            exp_last.delete();
            row_in.delete();
            stall_prev = 1'b0;
            pend_out   = 1'b0;
        end else begin
            checkOutput("busy", {31'b0, busy}, {31'b0, row_in.size() != 0});
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
            if (pend_out) checkOutput("latency_valid", {31'b0, out_valid}, 32'd1);
            if (stall_prev) begin
                checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
                checkOutput("hold_data", out_data, prev_data);
                checkOutput("hold_last", {31'b0, out_last}, {31'b0, prev_last});
            end
            if (out_valid && out_ready) begin
                checkOutput("out_expected", {31'b0, exp_data.size() != 0}, 32'd1);
                if (exp_data.size() != 0) begin
                    checkOutput("out_data", out_data, exp_data.pop_front());
                    checkOutput("out_last", {31'b0, out_last}, {31'b0, exp_last.pop_front()});
                end
                out_log.push_back(out_data);
                last_log.push_back(out_last);
            end
            pend_out = 1'b0;
            if (in_valid && in_ready) begin
                if (row_in.size() == 0) begin
                    m_key  = key;
                    m_iv   = iv;
                    m_mode = mode;
                    m_dir  = dir;
                end
                row_in.push_back(in_data);
                exp_data.push_back(modelBeat(m_key, m_iv, m_mode, m_dir, row_in));
                exp_last.push_back(row_in.size() == NBLK);
                if (row_in.size() == NBLK) row_in.delete();
                pend_out = 1'b1;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Offer one beat until it is accepted (bounded), then drop in_valid.
    task automatic applyStimulus(input logic [31:0] d, input logic rdy);
        logic acc;
        int   n;
        acc       = 1'b0;
        n         = 0;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = rdy;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checkOutput("accept_timeout", {31'b0, acc}, 32'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setConfig(input logic m, input logic d);
        key  = KEY_C;
        iv   = IV_C;
        mode = m;
        dir  = d;
    endtask

    task automatic zeroRow();
        for (int i = 0; i < NBLK; i++) applyStimulus(32'h0, 1'b1);
        drain();
    endtask

    task automatic checkRow(input string tag, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] e[3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        checkOutput({tag, "_count"}, out_log.size(), 32'd3);
        if (out_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("%s_data%0d", tag, i), out_log[i], e[i]);
                checkOutput($sformatf("%s_last%0d", tag, i), {31'b0, last_log[i]}, {31'b0, i == 2});
            end
        end
        out_log.delete();
        last_log.delete();
    endtask

    task automatic resetPulse();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        #1;
        resetPulse();

        // ECB encrypt of zeros
        setConfig(1'b0, 1'b0);
        zeroRow();
`ifdef XOR_CIPHER_KEY_ROTATE_EN
        checkRow("ecb_rot", 32'hA5A5A5A5, 32'h4B4B4B4B, 32'h96969696);
`else
        checkRow("ecb", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
`endif

`ifndef XOR_CIPHER_KEY_ROTATE_EN
        // CBC encrypt, then decrypt of the ciphertext, twice
        setConfig(1'b1, 1'b0);
        zeroRow();
        checkRow("cbc_enc", 32'hAAAAAAAA, 32'h0F0F0F0F, 32'hAAAAAAAA);
        for (int r = 0; r < 2; r++) begin
            setConfig(1'b1, 1'b1);
            applyStimulus(32'hAAAAAAAA, 1'b1);
            key = 32'h12345678;
            iv  = 32'hFFFFFFFF;
            mode = 1'b0;
            applyStimulus(32'h0F0F0F0F, 1'b1);
            applyStimulus(32'hAAAAAAAA, 1'b1);
            drain();
            checkRow("cbc_dec", 32'h0, 32'h0, 32'h0);
        end

        // Back-pressure on beat 1
        setConfig(1'b1, 1'b0);
        applyStimulus(32'h0, 1'b1);
        applyStimulus(32'h0, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_out_data", out_data, 32'h0F0F0F0F);
            @(posedge clk);
            #1;
        end
        applyStimulus(32'h0, 1'b1);
        drain();
        checkRow("bp", 32'hAAAAAAAA, 32'h0F0F0F0F, 32'hAAAAAAAA);
`endif

        // Randomised traffic: config ports change every cycle to show they are
        // only sampled at row start.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            key       = $urandom;
            iv        = $urandom;
            mode      = 1'($urandom_range(0, 1));
            dir       = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        drain();
        checkOutput("drain_empty", exp_data.size(), 32'd0);

        // Reset after beat 0 of a row, then a fresh row from iv
        resetPulse();
        setConfig(1'b1, 1'b0);
        applyStimulus(32'h0, 1'b1);
        resetPulse();
        checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
        out_log.delete();
        last_log.delete();
        setConfig(1'b1, 1'b0);
        zeroRow();
`ifdef XOR_CIPHER_KEY_ROTATE_EN
        checkRow("rst_row", 32'hAAAAAAAA, 32'h0F0F0F0F ^ 32'hA5A5A5A5 ^ 32'h4B4B4B4B, modelBeat(KEY_C, IV_C, 1'b1, 1'b0, '{32'h0, 32'h0, 32'h0}));
`else
        checkRow("rst_row", 32'hAAAAAAAA, 32'h0F0F0F0F, 32'hAAAAAAAA);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
